// File: rtl/edge_scan_ctrl.sv
// Frame-level raster sequencer for the edge-detection datapath.
// Handles border zeroing, the window/gradient/magnitude handshakes and output writes.
module edge_scan_ctrl #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int ADDR_W  = 19,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              window_req,
    output logic [ADDR_W-1:0] window_addr,
    input  logic              window_ready,
    output logic              calc_start,
    input  logic              calc_done,
    input  logic              output_enable,
    input  logic [3:0]        pixel_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    input  logic              wr_ack,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, CHECK, REQ_WIN, WAIT_WIN, CALC, WAIT_CALC, WAIT_MAG, WRITE, NEXT, DONE
    } state_t;

    state_t            state, next_state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        data_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              border, last_pixel, timed_out;

    assign border     = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
    assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);
    assign timed_out  = (wait_cnt >= CNT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = CHECK;
            CHECK:     next_state = border ? WRITE : REQ_WIN;
            REQ_WIN:   next_state = WAIT_WIN;
            WAIT_WIN:  if (window_ready) next_state = CALC;
            CALC:      next_state = WAIT_CALC;
            WAIT_CALC: begin
                if (calc_done && output_enable) next_state = WRITE;
                else if (calc_done)             next_state = WAIT_MAG;
                else if (timed_out)             next_state = WRITE;
            end
            WAIT_MAG:  if (output_enable || timed_out) next_state = WRITE;
            WRITE:     if (wr_ack) next_state = NEXT;
            NEXT:      next_state = last_pixel ? DONE : CHECK;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        window_req = 1'b0;
        calc_start = 1'b0;
        wr_en      = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            REQ_WIN: window_req = 1'b1;
            CALC:    calc_start = 1'b1;
            WRITE:   wr_en = 1'b1;
            DONE: begin
                frame_done = 1'b1;
                busy       = 1'b0;
            end
            default: ;
        endcase
    end

    // Pixel position, write data and the per-wait timeout counter; addr is a
    // running counter so no row*IMG_W multiply is needed.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col      <= '0;
            row      <= '0;
            addr     <= '0;
            data_q   <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        col  <= '0;
                        row  <= '0;
                        addr <= '0;
                        err  <= 1'b0;
                    end
                end
                CHECK: if (border) data_q <= '0;
                CALC:  wait_cnt <= '0;
                WAIT_CALC: begin
                    if (calc_done && output_enable) begin
                        data_q <= pixel_in;
                    end else if (calc_done) begin
                        wait_cnt <= '0;
                    end else if (timed_out) begin
                        err    <= 1'b1;
                        data_q <= '0;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                WAIT_MAG: begin
                    if (output_enable) begin
                        data_q <= pixel_in;
                    end else if (timed_out) begin
                        err    <= 1'b1;
                        data_q <= '0;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                NEXT: begin
                    if (!last_pixel) begin
                        addr <= addr + ADDR_W'(1);
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign window_addr = addr;
    assign wr_addr     = addr;
    assign wr_data     = data_q;

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Directed bench for edge_scan_ctrl on a 4x3 frame (interior pixels at addrs 5 and 6)
// with cycle-stepped responders for the window, gradient, magnitude and write ports.
module tb_edge_scan_ctrl;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 3;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 8;

    logic              tb_clk = 1'b0;
    logic              n_rst, start, window_ready, calc_done, output_enable, wr_ack;
    logic [3:0]        pixel_in;
    logic              window_req, calc_start, wr_en, busy, frame_done, err;
    logic [ADDR_W-1:0] window_addr, wr_addr;
    logic [3:0]        wr_data;

    int checks = 0;
    int errors = 0;

    edge_scan_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(tb_clk), .n_rst(n_rst), .start(start),
        .window_req(window_req), .window_addr(window_addr), .window_ready(window_ready),
        .calc_start(calc_start), .calc_done(calc_done), .output_enable(output_enable),
        .pixel_in(pixel_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode5: 0 = magnitude one cycle after calc_done, 1 = same cycle, 2 = calc_done never comes.
    // The mode applies to the first interior pixel (addr 5); addr 6 always answers normally with 4'hA.
    task automatic run_frame(input int mode5, input logic [3:0] pix5, input int ack_wait5,
                             input bit poke_start, input bit abort_mag,
                             input int exp_cycles, input bit exp_err);
        int         cyc = 0, n_writes = 0, n_wreq = 0, n_calc = 0, n_done = 0;
        int         wr_cycles = 0, wr5_cycles = 0, phase = 0, ack_after;
        logic [3:0] exp_data;
        bit         running = 1'b1;

        @(negedge tb_clk);
        start = 1'b1;
        while (running) begin
            @(negedge tb_clk);
            start = 1'b0; calc_done = 1'b0; output_enable = 1'b0; wr_ack = 1'b0; pixel_in = 4'h3;
            if (frame_done) begin
                n_done++;
                check_val("busy_low_in_done", busy, 0);
                start   = poke_start;
                running = 1'b0;
            end else if (cyc >= 200) begin
                check_val("frame_cycle_bound", cyc, exp_cycles);
                running = 1'b0;
            end else begin
                cyc++;
                check_val("busy_high", busy, 1);
                if (cyc == 1) check_val("err_cleared_on_start", err, 0);
                if (poke_start && cyc == 10) start = 1'b1;
                if (window_req) begin
                    n_wreq++;
                    check_val("window_addr", window_addr, (n_wreq == 1) ? 5 : 6);
                end
                if (calc_start) begin
                    n_calc++;
                    phase = 1;
                end else if (phase == 1) begin
                    if (n_calc == 1 && mode5 == 2) begin
                        phase = 1;
                    end else if (n_calc == 1 && mode5 == 1) begin
                        calc_done = 1'b1; output_enable = 1'b1; pixel_in = pix5; phase = 0;
                    end else begin
                        calc_done = 1'b1; phase = 2;
                    end
                end else if (phase == 2) begin
                    if (abort_mag) begin
                        check_val("err_before_reset", err, (mode5 == 2) ? 1 : 0);
                        n_rst = 1'b0;
                        #1;
                        check_val("rst_busy", busy, 0);
                        check_val("rst_wr_en", wr_en, 0);
                        check_val("rst_calc_start", calc_start, 0);
                        check_val("rst_window_req", window_req, 0);
                        check_val("rst_err", err, 0);
                        check_val("rst_frame_done", frame_done, 0);
                        @(negedge tb_clk);
                        n_rst = 1'b1;
                        return;
                    end
                    output_enable = 1'b1;
                    pixel_in = (n_calc == 1) ? pix5 : 4'hA;
                    phase = 0;
                end
                if (wr_en) begin
                    phase = 0;
                    exp_data = (n_writes == 5) ? ((mode5 == 2) ? 4'h0 : pix5) :
                               (n_writes == 6) ? 4'hA : 4'h0;
                    check_val("wr_addr", wr_addr, n_writes);
                    check_val("wr_data", wr_data, exp_data);
                    wr_cycles++;
                    ack_after = (n_writes == 5) ? ack_wait5 : 0;
                    if (wr_cycles > ack_after) begin
                        wr_ack = 1'b1;
                        if (n_writes == 5) wr5_cycles = wr_cycles;
                        n_writes++;
                        wr_cycles = 0;
                    end
                end
            end
        end

        check_val("write_count", n_writes, 12);
        check_val("window_req_count", n_wreq, 2);
        check_val("calc_start_count", n_calc, 2);
        check_val("frame_done_count", n_done, 1);
        check_val("frame_cycles", cyc, exp_cycles);
        if (ack_wait5 > 0) check_val("wr5_hold_cycles", wr5_cycles, ack_wait5 + 1);
        check_val("err_at_done", err, exp_err);
        @(negedge tb_clk);
        start = 1'b0;
        check_val("busy_after_done", busy, 0);
        check_val("frame_done_single", frame_done, 0);
        check_val("err_held_idle", err, exp_err);
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; window_ready = 1'b1; calc_done = 1'b0;
        output_enable = 1'b0; wr_ack = 1'b0; pixel_in = 4'h3;
        #12;
        check_val("reset_busy", busy, 0);
        check_val("reset_wr_en", wr_en, 0);
        check_val("reset_window_req", window_req, 0);
        check_val("reset_calc_start", calc_start, 0);
        check_val("reset_frame_done", frame_done, 0);
        check_val("reset_err", err, 0);
        check_val("reset_wr_addr", wr_addr, 0);
        check_val("reset_wr_data", wr_data, 0);
        @(negedge tb_clk);
        n_rst = 1'b1;
        @(negedge tb_clk);

        // 10 border pixels x 3 cycles + 2 interior x 8 cycles
        run_frame(0, 4'hA, 0, 1'b0, 1'b0, 46, 1'b0);
        run_frame(0, 4'hA, 3, 1'b0, 1'b0, 49, 1'b0);
        // addr 5 spends 8 cycles in WAIT_CALC and skips WAIT_MAG
        run_frame(2, 4'hA, 0, 1'b0, 1'b0, 52, 1'b1);
        run_frame(0, 4'hA, 0, 1'b1, 1'b0, 46, 1'b0);
        run_frame(1, 4'hF, 0, 1'b0, 1'b0, 45, 1'b0);
        // reset lands in WAIT_MAG of addr 6, after addr 5 has already timed out
        run_frame(2, 4'hA, 0, 1'b0, 1'b1, 0, 1'b0);
        run_frame(0, 4'hA, 0, 1'b0, 1'b0, 46, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_scan_ctrl.md
Name: edge_scan_ctrl

Overview:
Frame-level sequencer for the edge-detection datapath. Walks the image in raster order. For each interior pixel it requests a 3x3 window, starts the gradient unit, and waits for the magnitude block's 4-bit result; border pixels get 0. Every result is written to the output frame buffer with a valid/ack handshake. Sits between the top-level control/host interface, the line-buffer window fetch, the gradient/magnitude pipeline and the output SRAM port.

Parameters:
IMG_W, 640, image width in pixels (>=3)
IMG_H, 480, image height in pixels (>=3)
ADDR_W, 19, output address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
TIMEOUT, 64, maximum cycles to wait for calc_done or output_enable

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  reset, asynchronous, active-low
start  in  1  begin frame; sampled only in IDLE
window_req  out  1  one-cycle pulse: fetch 3x3 window centred on window_addr
window_addr  out  ADDR_W  linear address of centre pixel (row*IMG_W+col)
window_ready  in  1  window loaded into gradient unit inputs
calc_start  out  1  one-cycle pulse to gradient unit
calc_done  in  1  gradient result valid (also drives magnitude calc_done)
output_enable  in  1  magnitude result valid
pixel_in  in  4  magnitude result
wr_en  out  1  output write request
wr_addr  out  ADDR_W  output write address
wr_data  out  4  output write data
wr_ack  in  1  write accepted
busy  out  1  high from start acceptance until frame_done
frame_done  out  1  one-cycle pulse after last write accepted
err  out  1  sticky timeout flag; cleared on next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; row=col=0; all outputs 0, including err.
- States: IDLE, CHECK, REQ_WIN, WAIT_WIN, CALC, WAIT_CALC, WAIT_MAG, WRITE, NEXT, DONE.
- IDLE: start=1 -> CHECK. Accepting start clears row, col, addr and err, and sets busy. While busy, start is ignored.
- CHECK: border test on row==0, row==IMG_H-1, col==0, col==IMG_W-1.
  - Border -> WRITE with wr_data=0.
  - Interior -> REQ_WIN.
- REQ_WIN: window_req=1 for exactly 1 cycle; window_addr=current addr (held stable until NEXT) -> WAIT_WIN.
- WAIT_WIN: stays until window_ready=1 -> CALC. No timeout.
- CALC: calc_start=1 for exactly 1 cycle -> WAIT_CALC.
- WAIT_CALC: calc_done=1 -> WAIT_MAG.
- WAIT_MAG: output_enable=1 -> capture pixel_in into wr_data -> WRITE. Magnitude asserts output_enable 1 cycle after calc_done; a same-cycle calc_done and output_enable in WAIT_CALC is also accepted directly (capture, -> WRITE).
- Timeout: wait counter resets on entry to WAIT_CALC/WAIT_MAG. Reaching TIMEOUT cycles -> err=1, wr_data=0 -> WRITE. The frame continues.
- WRITE: wr_en=1 with wr_addr=addr and wr_data held stable until wr_ack sampled high; wr_ack in the first cycle is allowed (1-cycle write). Then -> NEXT; wr_en drops the same edge.
- NEXT:
  - col==IMG_W-1 and row==IMG_H-1 -> DONE.
  - Else col==IMG_W-1 -> col=0, row+1.
  - Else col+1.
  - addr increments by 1 each pixel (counter, no multiplier) -> CHECK.
- DONE: frame_done=1 for 1 cycle, busy=0 -> IDLE. A start arriving in the DONE cycle is ignored.
- Spurious calc_done/output_enable/window_ready in other states: ignored.
- Per-pixel latency with zero-wait responders: border 3 cycles (CHECK, WRITE, NEXT); interior 8 cycles (CHECK, REQ_WIN, WAIT_WIN, CALC, WAIT_CALC, WAIT_MAG, WRITE, NEXT).
- Counters: col width clog2(IMG_W), row width clog2(IMG_H), addr ADDR_W, all unsigned with no wrap inside a frame. The timeout counter saturates.

Test Plan:
- Reset mid-frame: IMG_W=4, IMG_H=3; assert n_rst=0 asynchronously while in WAIT_MAG -> same-time return of busy, wr_en, calc_start, err to 0; next start restarts at addr 0.
- Full small frame: IMG_W=4, IMG_H=3; responders ack immediately and magnitude returns 4'hA at addrs 5 and 6 -> 12 writes in order 0..11; data 0 except addr5=addr6=4'hA; window_req only for addrs 5 and 6; frame_done one pulse; busy high throughout.
- Write backpressure: wr_ack delayed 3 cycles on addr 5 -> wr_en, wr_addr=5, wr_data=4'hA stable for 4 cycles; no skipped or duplicated address.
- Timeout: TIMEOUT=8, calc_done never asserted for addr 5 -> after 8 cycles err=1, addr 5 written 0, frame completes; err stays 1 until next start, then clears.
- Start while busy: pulse start mid-frame and in the DONE cycle -> no restart, exactly 12 writes, one frame_done.
- Magnitude same-cycle: calc_done and output_enable together with pixel_in=4'hF -> 4'hF written; timing matches the 1-cycle-late case minus one cycle.
